// File: rtl/gray2bin_stream.sv
// Streaming Gray-to-binary decoder with a valid/ready handshake and a pipeline of
// configurable depth. Adjacent accepted codes must differ in one bit; words that
// break this rule are flagged and counted.
module gray2bin_stream #(
    parameter int unsigned p_DATA_WIDTH   = 32,
    parameter int unsigned p_STAGES       = 2,
    parameter int unsigned p_ALLOW_REPEAT = 1,
    parameter int unsigned p_CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [p_DATA_WIDTH-1:0] i_gray,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [p_DATA_WIDTH-1:0] o_bin,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_seq_err,
    output logic [p_CNT_WIDTH-1:0]  o_err_cnt,
    input  logic                    i_err_clr
);

    localparam int unsigned W     = p_DATA_WIDTH;
    localparam int unsigned S     = p_STAGES;
    localparam int unsigned CW    = p_CNT_WIDTH;
    // Bits decoded per stage, taken from the MSB downwards.
    localparam int unsigned CHUNK = (W + S - 1) / S;

    // Decode the bits owned by one slice; bits above it are already binary.
    function automatic logic [W-1:0] decode_slice(input logic [W-1:0] word, input int slice);
        logic [W-1:0] res;
        res = word;
        for (int i = int'(W) - 2; i >= 0; i--) begin
            if (((int'(W) - 1 - i) / int'(CHUNK)) == slice) begin
                res[i] = res[i+1] ^ word[i];
            end
        end
        return res;
    endfunction

    // Number of set bits in a word.
    function automatic int unsigned popcount(input logic [W-1:0] word);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(W); i++) begin
            n = n + 32'(word[i]);
        end
        return n;
    endfunction

    logic [W-1:0]  st_data [S];
    logic [S-1:0]  st_vld;
    logic [S-1:0]  st_err;
    logic [S-1:0]  load;
    logic          tail_full;
    logic          accept;
    logic          seq_err;
    logic [W-1:0]  gray_diff;
    int unsigned   diff_ones;
    logic [W-1:0]  prev_gray;
    logic          prev_valid;

    // A stage may load when it, or any stage after it, is empty, or when the sink is taking a word.
    always_comb begin
        load      = '0;
        tail_full = 1'b1;
        for (int k = 0; k < int'(S); k++) begin
            tail_full = 1'b1;
            for (int j = k; j < int'(S); j++) begin
                tail_full = tail_full & st_vld[j];
            end
            load[k] = i_ready | ~tail_full;
        end
    end

    // Adjacency check of the incoming code against the last accepted code.
    always_comb begin
        gray_diff = i_gray ^ prev_gray;
        diff_ones = popcount(gray_diff);
        seq_err   = prev_valid &&
                    ((diff_ones > 1) || ((p_ALLOW_REPEAT == 0) && (diff_ones == 0)));
    end

    assign o_ready   = load[0];
    assign accept    = i_valid & o_ready;
    assign o_bin     = st_data[S-1];
    assign o_valid   = st_vld[S-1];
    assign o_seq_err = st_err[S-1];

    // Pipeline registers: each stage decodes its slice on the way in; empty stages collapse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_vld <= '0;
            st_err <= '0;
            for (int k = 0; k < int'(S); k++) begin
                st_data[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                st_data[0] <= decode_slice(i_gray, 0);
                st_vld[0]  <= accept;
                st_err[0]  <= accept & seq_err;
            end
            for (int k = 1; k < int'(S); k++) begin
                if (load[k]) begin
                    st_data[k] <= decode_slice(st_data[k-1], k);
                    st_vld[k]  <= st_vld[k-1];
                    st_err[k]  <= st_err[k-1];
                end
            end
        end
    end

    // Last accepted code, tracked for every accepted word including flagged ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_gray  <= '0;
            prev_valid <= 1'b0;
        end else if (accept) begin
            prev_gray  <= i_gray;
            prev_valid <= 1'b1;
        end
    end

    // Saturating error counter; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt <= '0;
        end else if (i_err_clr) begin
            o_err_cnt <= '0;
        end else if (accept && seq_err && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + CW'(1);
        end
    end

endmodule
